// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between execute stage and the load/store unit.
//   req_*  : execute -> LSU request (valid/ready), with store data and access size
//   resp_* : LSU -> write-back response (valid/ready), with load data and error flag
// master modport is the execute/write-back side; slave modport is the LSU.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-addressed synchronous data memory.
// Byte/half stores are done as read-modify-write; loads are lane-selected and
// sign/zero-extended. Misaligned or reserved-size requests answer with an error
// and never touch memory.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : request/response handshakes (load_store_unit_if)
//   mem_address      : word index, zero-extended req_addr[ADDR_BITS+1:2]
//   mem_write_data   : full word to write
//   mem_to_reg       : 1 = read, 0 = write (memory writes on every edge while low)
//   mem_read_data    : memory read data, valid the cycle after a read edge
// Build option: LSU_BOUNDS_CHECK_EN flags requests with nonzero address bits
// above the memory range as errors; otherwise those bits alias.
module load_store_unit #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  load_store_unit_if.slave      bus,
  output logic [31:0]           mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_to_reg,
  input  logic [31:0]           mem_read_data
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_MERGE, S_WR, S_RESP
  } state_t;

  state_t          r_state, w_state;
  logic            r_we, w_we;
  logic [1:0]      r_size, w_size;
  logic            r_signed, w_signed;
  logic [1:0]      r_lane, w_lane;
  logic [15:0]     r_wdata, w_wdata;
  logic [AW-1:0]   r_mem_address, w_mem_address;
  logic [DW-1:0]   r_mem_write_data, w_mem_write_data;
  logic            r_mem_to_reg, w_mem_to_reg;
  logic            r_req_ready, w_req_ready;
  logic            r_resp_valid, w_resp_valid;
  logic [DW-1:0]   r_resp_data, w_resp_data;
  logic            r_resp_err, w_resp_err;

  logic            w_accept;
  logic            w_oob;
  logic            w_err;
  logic [4:0]      w_byte_sh;
  logic [4:0]      w_half_sh;
  logic [DW-1:0]   w_rd_byte_sh;
  logic [DW-1:0]   w_rd_half_sh;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [DW-1:0]   w_load_ext;
  logic [DW-1:0]   w_merge_mask;
  logic [DW-1:0]   w_merge_val;
  logic [DW-1:0]   w_merged;

  assign w_accept = bus.req_valid && r_req_ready;

`ifdef LSU_BOUNDS_CHECK_EN
  assign w_oob = |bus.req_addr[AW-1:ADDR_BITS+2];
`else
  logic w_unused_addr;
  assign w_oob         = 1'b0;
  assign w_unused_addr = ^bus.req_addr[AW-1:ADDR_BITS+2];
`endif

  // Request legality, evaluated against the live request at accept
  assign w_err = (bus.req_size == 2'b11)
              || (bus.req_size == 2'b01 && bus.req_addr[0])
              || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
              || w_oob;

  // Little-endian lane select and extension of the word just read
  assign w_byte_sh    = {r_lane, 3'b000};
  assign w_half_sh    = {r_lane[1], 4'b0000};
  assign w_rd_byte_sh = mem_read_data >> w_byte_sh;
  assign w_rd_half_sh = mem_read_data >> w_half_sh;
  assign w_byte       = w_rd_byte_sh[7:0];
  assign w_half       = w_rd_half_sh[15:0];

  always_comb begin
    w_load_ext = mem_read_data;
    case (r_size)
      2'b00:   w_load_ext = r_signed ? {{24{w_byte[7]}}, w_byte} : DW'(w_byte);
      2'b01:   w_load_ext = r_signed ? {{16{w_half[15]}}, w_half} : DW'(w_half);
      default: w_load_ext = mem_read_data;
    endcase
  end

  // Replace the target lane of the old word with the captured store data
  always_comb begin
    w_merge_mask = DW'(16'hFFFF) << w_half_sh;
    w_merge_val  = DW'(r_wdata) << w_half_sh;
    if (r_size == 2'b00) begin
      w_merge_mask = DW'(8'hFF) << w_byte_sh;
      w_merge_val  = DW'(r_wdata[7:0]) << w_byte_sh;
    end
    w_merged = (mem_read_data & ~w_merge_mask) | (w_merge_val & w_merge_mask);
  end

  // Next-state and next-register values
  always_comb begin
    w_state          = r_state;
    w_we             = r_we;
    w_size           = r_size;
    w_signed         = r_signed;
    w_lane           = r_lane;
    w_wdata          = r_wdata;
    w_mem_address    = r_mem_address;
    w_mem_write_data = r_mem_write_data;
    w_resp_data      = r_resp_data;
    w_resp_err       = r_resp_err;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_we          = bus.req_we;
          w_size        = bus.req_size;
          w_signed      = bus.req_signed;
          w_lane        = bus.req_addr[1:0];
          w_wdata       = bus.req_wdata[15:0];
          w_mem_address = AW'(bus.req_addr[ADDR_BITS+1:2]);
          w_resp_data   = '0;
          w_resp_err    = w_err;
          if (w_err) begin
            w_state = S_RESP;
          end else if (bus.req_we && bus.req_size == 2'b10) begin
            w_state          = S_WR;
            w_mem_write_data = bus.req_wdata;
          end else begin
            w_state = S_RD;
          end
        end
      end
      S_RD:    w_state = r_we ? S_MERGE : S_CAP;
      S_CAP: begin
        w_resp_data = w_load_ext;
        w_state     = S_RESP;
      end
      S_MERGE: begin
        w_mem_write_data = w_merged;
        w_state          = S_WR;
      end
      S_WR:    w_state = S_RESP;
      S_RESP:  if (bus.resp_ready) w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Handshake and memory strobes are registered copies of the next state
    w_req_ready  = (w_state == S_IDLE);
    w_resp_valid = (w_state == S_RESP);
    w_mem_to_reg = (w_state != S_WR);
  end

  // State register; reset forces mem_to_reg high immediately to abort a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_we             <= 1'b0;
      r_size           <= 2'b00;
      r_signed         <= 1'b0;
      r_lane           <= 2'b00;
      r_wdata          <= '0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_to_reg     <= 1'b1;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp_data      <= '0;
      r_resp_err       <= 1'b0;
    end else begin
      r_state          <= w_state;
      r_we             <= w_we;
      r_size           <= w_size;
      r_signed         <= w_signed;
      r_lane           <= w_lane;
      r_wdata          <= w_wdata;
      r_mem_address    <= w_mem_address;
      r_mem_write_data <= w_mem_write_data;
      r_mem_to_reg     <= w_mem_to_reg;
      r_req_ready      <= w_req_ready;
      r_resp_valid     <= w_resp_valid;
      r_resp_data      <= w_resp_data;
      r_resp_err       <= w_resp_err;
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign mem_to_reg     = r_mem_to_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural synchronous memory.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_to_reg;
  logic [31:0] mem_read_data;

  load_store_unit_if u_if();

  load_store_unit #(.ADDR_BITS(8)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (u_if),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_to_reg     (mem_to_reg),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Synchronous word memory: writes whenever mem_to_reg is low, registered read
  logic [31:0] mem [256];
  int          wr_cnt = 0;
  always @(posedge clk) begin
    if (!mem_to_reg) begin
      mem[mem_address[7:0]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    mem_read_data <= mem[mem_address[7:0]];
  end

  typedef struct packed { logic err; logic [31:0] data; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] model_mem [256];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request through to response; expectation comes from the reference model
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input int hold);
    exp_t        e;
    logic        err;
    int          lat, wexp, c, w0;
    logic [31:0] w, d0;
    logic [7:0]  b;
    logic [15:0] h;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`ifdef LSU_BOUNDS_CHECK_EN
    err = err || (a[31:10] != 22'd0);
`endif
    w = model_mem[a[9:2]];
    e.err = err;
    e.data = 32'd0;
    wexp = 0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      case (sz)
        2'b00:   w[8*a[1:0] +: 8] = wd[7:0];
        2'b01:   w[16*a[1] +: 16] = wd[15:0];
        default: w = wd;
      endcase
      model_mem[a[9:2]] = w;
      lat = (sz == 2'b10) ? 2 : 4;
      wexp = 1;
    end else begin
      lat = 3;
      b = w[8*a[1:0] +: 8];
      h = w[16*a[1] +: 16];
      case (sz)
        2'b00:   e.data = (sg && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
        2'b01:   e.data = (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
        default: e.data = w;
      endcase
    end

    @(negedge clk);
    sb_q.push_back(e);
    u_if.req_valid  = 1'b1;
    u_if.req_we     = we;
    u_if.req_size   = sz;
    u_if.req_signed = sg;
    u_if.req_addr   = a;
    u_if.req_wdata  = wd;
    c = 0;
    while (!u_if.req_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (c >= 20) chk("req_ready_timeout", 32'(u_if.req_ready), 32'd1);
    w0 = wr_cnt;
    @(posedge clk);
    #1 u_if.req_valid = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!u_if.resp_valid && c < 20);
    chk("resp_latency", 32'(c), 32'(lat));
    if (!err) chk("mem_address", mem_address, {24'h0, a[9:2]});
    e = sb_q.pop_front();
    chk("resp_err", 32'(u_if.resp_err), 32'(e.err));
    chk("resp_data", u_if.resp_data, e.data);
    d0 = u_if.resp_data;
    last_data = d0;
    repeat (hold) begin
      @(negedge clk);
      chk("bp_valid", 32'(u_if.resp_valid), 32'd1);
      chk("bp_data", u_if.resp_data, d0);
      chk("bp_req_ready", 32'(u_if.req_ready), 32'd0);
    end
    u_if.resp_ready = 1'b1;
    @(posedge clk);
    #1 u_if.resp_ready = 1'b0;
    chk("write_edges", 32'(wr_cnt - w0), 32'(wexp));
    @(negedge clk);
    chk("req_ready_back", 32'(u_if.req_ready), 32'd1);
  endtask

  initial begin
    int c;
    u_if.req_valid  = 1'b0;
    u_if.req_we     = 1'b0;
    u_if.req_size   = 2'b00;
    u_if.req_signed = 1'b0;
    u_if.req_addr   = '0;
    u_if.req_wdata  = '0;
    u_if.resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(u_if.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(u_if.resp_valid), 32'd0);
    chk("rst_resp_data", u_if.resp_data, 32'd0);
    chk("rst_resp_err", 32'(u_if.resp_err), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_mem_to_reg", 32'(mem_to_reg), 32'd1);
    rst_n = 1'b1;

    // Word store / load round trip
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    chk("tp_word", last_data, 32'hDEADBEEF);
    // Byte store then signed, unsigned and word loads
    xact(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000080, 0);
    xact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
    chk("tp_sbyte", last_data, 32'hFFFFFF80);
    xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0);
    chk("tp_ubyte", last_data, 32'h00000080);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    chk("tp_merged", last_data, 32'hDEAD80EF);
    // Misaligned half, misaligned word, reserved size
    xact(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 0);
    xact(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 0);
    xact(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 0);
    // Half store/load both halves, signed and unsigned
    xact(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000F00D, 0);
    xact(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 0);
    xact(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 0);
    // Back-pressure on a load response
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
    // Out-of-range address: error with bounds check, alias of word 0 without
    xact(1'b1, 2'b10, 1'b0, 32'h0, 32'h13579BDF, 0);
    xact(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0);

    // Reset during WR of a half store must not write
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA, 0);
    @(negedge clk);
    u_if.req_valid = 1'b1;
    u_if.req_we    = 1'b1;
    u_if.req_size  = 2'b01;
    u_if.req_addr  = 32'h20;
    u_if.req_wdata = 32'h00001234;
    @(posedge clk);
    #1 u_if.req_valid = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (mem_to_reg && c < 10);
    chk("wr_state_cycle", 32'(c), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_async_mem_to_reg", 32'(mem_to_reg), 32'd1);
    chk("rst_async_req_ready", 32'(u_if.req_ready), 32'd1);
    chk("rst_async_resp_valid", 32'(u_if.resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
    chk("tp_rst_abort", last_data, 32'hAAAAAAAA);

    // Randomised mix over eight pre-initialised words
    for (int i = 0; i < 8; i++) xact(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 0);
    for (int i = 0; i < 40; i++)
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 31)), $urandom, (i % 10 == 0) ? 2 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
